stereo_line_merge: RTL
======================

Name: stereo_line_merge

Overview:
Sits directly downstream of the dual-camera synchroniser, in the rclk domain. Consumes the aligned pixel pairs (camera 1 and camera 2 pixel on the same valid beat) and produces one side-by-side video line of 2*H_ACT pixels: all camera 1 pixels first, then all camera 2 pixels. Uses ping-pong line buffers and a valid/ready output stream toward the frame-buffer writer.

Parameters:
H_ACT, 1280, active pixels per camera line; the output line is 2*H_ACT pixels.
DW, 16, pixel width (RGB565).

Ports:
rclk  in  1  clock for all logic
rst  in  1  synchronous, active-high reset
in_pixel_1  in  DW  camera 1 pixel
in_pixel_2  in  DW  camera 2 pixel
in_valid  in  1  pixel pair valid; no backpressure
in_vsync  in  1  one-cycle frame-start pulse
out_data  out  DW  merged pixel
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
out_sol  out  1  first pixel of output line, qualified by out_valid
out_eol  out  1  last pixel of output line, qualified by out_valid
out_sof  out  1  first pixel of first line after in_vsync, qualified by out_valid
overflow  out  1  sticky: an input line was dropped

Behaviour:
- Reset (rst=1 at a rclk edge): out_valid=0, out_sol=0, out_eol=0, out_sof=0, overflow=0. Also clears wr_x=0, wr_bank=0, rd_bank=0, bank_full[1:0]=0, read FSM=IDLE, sof_pending=1.
- Storage: 2 banks, each holding H_ACT entries of camera 1 and H_ACT entries of camera 2. Synchronous RAM, 1-cycle read latency.
- Write side:
  - At wr_x==0 with in_valid, the line is accepted if bank_full[wr_bank]==0. A bank released by the reader in the same cycle counts as free.
  - If not accepted, the whole line is dropped: overflow<=1, pixels are counted but not written, and wr_bank is unchanged.
  - Each in_valid beat writes both pixels at address wr_x (when the line is accepted), then wr_x increments.
  - At wr_x==H_ACT-1: wr_x<=0. If accepted, bank_full[wr_bank]<=1 and wr_bank toggles.
- Read FSM:
  - IDLE: if bank_full[rd_bank], go to LEFT.
  - LEFT: streams camera 1 entries 0..H_ACT-1, then goes to RIGHT.
  - RIGHT: streams camera 2 entries 0..H_ACT-1. On the last handshake: bank_full[rd_bank]<=0, rd_bank toggles, FSM goes to IDLE.
- Output stream (AXI-stream rules):
  - A beat transfers when out_valid&&out_ready.
  - While out_valid=1 and out_ready=0, out_data and all flags hold stable.
  - out_valid never drops without a handshake, except on rst or in_vsync.
  - Prefetch/skid logic must hide RAM latency.
- Output flags:
  - out_sol on LEFT entry 0.
  - out_eol on RIGHT entry H_ACT-1.
  - out_sof = out_sol && sof_pending; sof_pending clears on that handshake.
- Throughput and latency:
  - With out_ready held high, the 2*H_ACT beats are contiguous, with no bubble at the LEFT/RIGHT boundary.
  - The first out_valid comes ≤3 cycles after bank_full sets.
  - Back-to-back full banks stream with ≤2 idle cycles between lines.
- in_vsync:
  - Same effect as reset on wr_x, wr_bank, rd_bank, bank_full, FSM and output valid; sets sof_pending=1.
  - overflow is not cleared.
  - If in_valid coincides with in_vsync, that pixel is x=0 of the new frame.
  - A partially output line is abandoned, with no eol.
- Write and read never touch the same bank concurrently, because a bank is written only while bank_full=0.
- Counters: wr_x and the read index are $clog2(H_ACT) bits wide. Comparisons use H_ACT-1, so no wrap beyond H_ACT.

Test Plan:
- H_ACT=8, out_ready=1, one line with p1=0x0100+x and p2=0x0200+x -> 16 contiguous beats 0x0100..0x0107 then 0x0200..0x0207; sol+sof on beat 0, eol on beat 15; overflow=0.
- Three lines back-to-back, out_ready=0 throughout -> lines 0 and 1 stored, line 2 dropped and overflow=1. Then release ready -> exactly lines 0 and 1 output, in order, 32 beats.
- Random out_ready (50%) over 4 lines -> data and flags stable during stalls; all 64 beats in order; no duplicates.
- in_vsync asserted mid-output of line 0 (beat 5) -> out_valid drops the next cycle; a following line outputs with out_sof=1 on its first beat.
- in_vsync coinciding with in_valid -> that pixel appears as output beat 0 of the next line; overflow is unchanged by in_vsync.
- rst asserted mid-write and mid-read -> all outputs 0 next cycle; the next full line outputs correctly with sof.

Source files
------------

// File: rtl/stereo_line_merge.sv
// Side-by-side stereo line merger: ping-pong line banks hold camera 1/2 lines,
// a read FSM streams camera 1 then camera 2 through a 2-deep output buffer.
module stereo_line_merge #(
  parameter int H_ACT = 1280,
  parameter int DW    = 16
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic [DW-1:0] in_pixel_1,
  input  logic [DW-1:0] in_pixel_2,
  input  logic          in_valid,
  input  logic          in_vsync,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sol,
  output logic          out_eol,
  output logic          out_sof,
  output logic          overflow
);
  localparam int XW = $clog2(H_ACT);
  localparam int AW = $clog2(2*H_ACT);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT-1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} rd_state_e;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          sol;
    logic          eol;
  } beat_t;

  logic [DW-1:0] mem1 [2*H_ACT];
  logic [DW-1:0] mem2 [2*H_ACT];

  // write side
  logic [XW-1:0] wr_x_q, wr_x_d, wx;
  logic          wr_bank_q, wr_bank_d, wb;
  logic          line_ok_q, line_ok;
  logic [1:0]    bank_full_q, bank_full_d, bf;
  logic          overflow_q, bank_free, wr_en, wr_last;
  logic [AW-1:0] wr_addr;

  // read side
  rd_state_e     state_q, state_d;
  logic [XW-1:0] rd_x_q, rd_x_d, rd_xe;
  logic          rd_bank_q, rd_bank_d, done_q, done_d, sof_pend_q;
  logic          rd_vld_q, rd_cam_q, rd_sol_q, rd_eol_q;
  logic [DW-1:0] ram1_q, ram2_q;
  logic [AW-1:0] rd_addr;
  logic          want, can_issue, issue, pop, push, rel_rd;
  logic [2:0]    occ;
  beat_t         fifo_q [2];
  beat_t         head, push_beat;
  logic          wptr_q, rptr_q;
  logic [1:0]    cnt_q;

  // in_vsync acts as an implicit frame reset that the same-cycle pixel already sees
  assign wx        = in_vsync ? '0 : wr_x_q;
  assign wb        = in_vsync ? 1'b0 : wr_bank_q;
  assign bf        = in_vsync ? 2'b00 : bank_full_q;
  assign bank_free = !bf[wb] || (rel_rd && !in_vsync && rd_bank_q == wb);
  assign line_ok   = (wx == '0) ? bank_free : line_ok_q;
  assign wr_en     = in_valid && line_ok;
  assign wr_last   = in_valid && wx == X_LAST;
  assign wr_addr   = AW'(wx) + (wb ? AW'(H_ACT) : '0);

  always_comb begin
    wr_x_d      = wx;
    wr_bank_d   = wb;
    bank_full_d = bf;
    if (rel_rd && !in_vsync) bank_full_d[rd_bank_q] = 1'b0;
    if (in_valid) wr_x_d = wr_last ? '0 : wx + XW'(1);
    if (wr_last && line_ok) begin
      bank_full_d[wb] = 1'b1;
      wr_bank_d       = ~wb;
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      wr_x_q      <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      line_ok_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_x_q      <= wr_x_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      if (in_valid) line_ok_q <= line_ok;
      if (in_valid && wx == '0 && !bank_free) overflow_q <= 1'b1;
    end
  end

  // output buffer head drives the stream directly, so it holds still under stall
  assign head      = fifo_q[rptr_q];
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = head.data;
  assign out_sol   = out_valid && head.sol;
  assign out_eol   = out_valid && head.eol;
  assign out_sof   = out_sol && sof_pend_q;
  assign overflow  = overflow_q;
  assign pop       = out_valid && out_ready;
  assign rel_rd    = pop && head.eol;

  // issue only if the buffer can absorb the beat after the 1-cycle RAM latency
  assign occ       = {1'b0, cnt_q} + {2'b00, rd_vld_q};
  assign can_issue = occ <= ({2'b00, pop} + 3'd1);
  assign want      = (state_q == IDLE && bank_full_q[rd_bank_q]) || state_q == LEFT ||
                     (state_q == RIGHT && !done_q);
  assign issue     = want && can_issue && !in_vsync;
  assign rd_xe     = (state_q == IDLE) ? '0 : rd_x_q;
  assign rd_addr   = AW'(rd_xe) + (rd_bank_q ? AW'(H_ACT) : '0);

  always_comb begin
    state_d   = state_q;
    rd_x_d    = rd_x_q;
    done_d    = done_q;
    rd_bank_d = rd_bank_q;
    unique case (state_q)
      IDLE: if (issue) begin
        state_d = LEFT;
        rd_x_d  = XW'(1);
      end
      LEFT: if (issue) begin
        if (rd_x_q == X_LAST) begin
          state_d = RIGHT;
          rd_x_d  = '0;
        end else rd_x_d = rd_x_q + XW'(1);
      end
      RIGHT: begin
        if (issue) begin
          if (rd_x_q == X_LAST) done_d = 1'b1;
          else rd_x_d = rd_x_q + XW'(1);
        end
        if (rel_rd) begin
          state_d   = IDLE;
          rd_x_d    = '0;
          done_d    = 1'b0;
          rd_bank_d = ~rd_bank_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (wr_en) begin
      mem1[wr_addr] <= in_pixel_1;
      mem2[wr_addr] <= in_pixel_2;
    end
    ram1_q <= mem1[rd_addr];
    ram2_q <= mem2[rd_addr];
  end

  assign push      = rd_vld_q;
  assign push_beat = '{data: rd_cam_q ? ram2_q : ram1_q, sol: rd_sol_q, eol: rd_eol_q};

  always_ff @(posedge rclk) begin
    if (rst || in_vsync) begin
      state_q    <= IDLE;
      rd_x_q     <= '0;
      rd_bank_q  <= 1'b0;
      done_q     <= 1'b0;
      sof_pend_q <= 1'b1;
      rd_vld_q   <= 1'b0;
      rd_cam_q   <= 1'b0;
      rd_sol_q   <= 1'b0;
      rd_eol_q   <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q   <= state_d;
      rd_x_q    <= rd_x_d;
      rd_bank_q <= rd_bank_d;
      done_q    <= done_d;
      if (pop && out_sof) sof_pend_q <= 1'b0;
      rd_vld_q  <= issue;
      rd_cam_q  <= state_q == RIGHT;
      rd_sol_q  <= state_q == IDLE;
      rd_eol_q  <= state_q == RIGHT && rd_x_q == X_LAST;
      if (push) begin
        fifo_q[wptr_q] <= push_beat;
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
